// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector. Y pulses one clock after the bit that completes the pattern; no backpressure, en qualifies bits.
// Match counter flops exist only when SEQDET_CNT_EN is defined, otherwise match_cnt is tied to 0.
module seq_detector_param #(
  parameter int              PAT_W   = 3,
  parameter logic [PAT_W-1:0] PAT_RST = 3'b101,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             X,
  input  logic             en,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic             overlap,
  output logic             Y,
  output logic [CNT_W-1:0] match_cnt,
  output logic [PAT_W-1:0] pattern_q
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);

  typedef enum logic {FILL, HUNT} state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [PAT_W-1:0] pattern_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             y_q, y_d;

  logic [PAT_W-1:0] hist_sh;
  logic [FW-1:0]    fill_nx;
  logic             full_nx;
  logic             match;

  always_comb begin
    hist_sh = {hist_q[PAT_W-2:0], X};
    // Fill is already saturated in HUNT, so only FILL needs to count.
    fill_nx = (state_q == HUNT) ? fill_q : fill_q + 1'b1;
    full_nx = (fill_nx == FILL_FULL);
    match   = en && full_nx && (hist_sh == pattern_q);

    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    y_d       = 1'b0;

    if (load) begin
      pattern_d = pattern_in;
      hist_d    = '0;
      fill_d    = '0;
      state_d   = FILL;
    end else if (en) begin
      hist_d  = hist_sh;
      fill_d  = fill_nx;
      state_d = full_nx ? HUNT : FILL;
      if (match) begin
        y_d = 1'b1;
        if (!overlap) begin
          fill_d  = '0;
          state_d = FILL;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= PAT_RST;
      y_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      y_q       <= y_d;
    end
  end

  assign Y = y_q;

`ifdef SEQDET_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: a 3-bit default instance and a 4-bit/2-bit-counter instance share one stream.
module tb_seq_detector_param;

  logic       clk;
  logic       rst_n;
  logic       x, en, load, overlap;
  logic [2:0] pin0;
  logic [3:0] pin1;
  logic       y0, y1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [2:0] pq0;
  logic [3:0] pq1;

  int checks = 0;
  int failures = 0;

  // Behavioural model: per instance, the bits seen since the window last restarted.
  bit         mq[2][$];
  logic [15:0] mp[2];
  int         mc[2];
  bit         ey[2];
  int         mw[2]   = '{3, 4};
  int         mmax[2] = '{255, 3};

`ifdef SEQDET_CNT_EN
  localparam int CE = 1;
`else
  localparam int CE = 0;
`endif

  seq_detector_param dut0 (
    .clk(clk), .rst_n(rst_n), .X(x), .en(en), .load(load), .pattern_in(pin0),
    .overlap(overlap), .Y(y0), .match_cnt(cnt0), .pattern_q(pq0)
  );

  seq_detector_param #(.PAT_W(4), .PAT_RST(4'b0110), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .X(x), .en(en), .load(load), .pattern_in(pin1),
    .overlap(overlap), .Y(y1), .match_cnt(cnt1), .pattern_q(pq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ecnt(int k);
    return (CE != 0) ? mc[k] : 0;
  endfunction

  function automatic bit win_match(int k);
    if (mq[k].size() != mw[k]) return 1'b0;
    for (int i = 0; i < mw[k]; i++)
      if (mq[k][i] != mp[k][mw[k]-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mc[k] = 0;
      ey[k] = 1'b0;
    end
    mp[0] = 16'h0005;
    mp[1] = 16'h0006;
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (load) begin
        mp[k] = (k == 0) ? 16'(pin0) : 16'(pin1);
        mq[k].delete();
        mc[k] = 0;
        ey[k] = 1'b0;
      end else if (en) begin
        mq[k].push_back(x);
        if (mq[k].size() > mw[k]) void'(mq[k].pop_front());
        ey[k] = win_match(k);
        if (ey[k]) begin
          if (mc[k] < mmax[k]) mc[k]++;
          if (!overlap) mq[k].delete();
        end
      end else begin
        ey[k] = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_y0"},   32'(y0),   32'(ey[0]));
    chk({tag, "_cnt0"}, 32'(cnt0), 32'(ecnt(0)));
    chk({tag, "_pat0"}, 32'(pq0),  32'(mp[0]));
    chk({tag, "_y1"},   32'(y1),   32'(ey[1]));
    chk({tag, "_cnt1"}, 32'(cnt1), 32'(ecnt(1)));
    chk({tag, "_pat1"}, 32'(pq1),  32'(mp[1]));
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
  task automatic step(input logic xi, input logic ei, input logic li, input logic oi);
    x = xi; en = ei; load = li; overlap = oi;
    @(posedge clk);
    model_edge();
    #1;
    check_all("step");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all("rst_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("rst_held");
  endtask

  task automatic do_load(input logic [2:0] p0, input logic [3:0] p1, input logic xi, input logic oi);
    pin0 = p0; pin1 = p1;
    step(xi, 1'b1, 1'b1, oi);
  endtask

  initial begin
    rst_n = 1'b1; x = 1'b0; en = 1'b0; load = 1'b0; overlap = 1'b1;
    pin0 = 3'b000; pin1 = 4'b0000;
    #1;
    do_reset();
    chk("reset_y0", 32'(y0), 32'd0);
    chk("reset_pat0", 32'(pq0), 32'h5);
    chk("reset_pat1", 32'(pq1), 32'h6);

    // Overlapping 101 on the default instance.
    step(1, 1, 0, 1); step(0, 1, 0, 1); step(1, 1, 0, 1);
    chk("tp1_pulse_a", 32'(y0), 32'd1);
    step(0, 1, 0, 1);
    chk("tp1_gap", 32'(y0), 32'd0);
    step(1, 1, 0, 1);
    chk("tp1_pulse_b", 32'(y0), 32'd1);
    chk("tp1_cnt0", 32'(cnt0), 32'(2 * CE));

    // Same stream, non-overlapping; the load-cycle X=1 is discarded.
    do_load(3'b101, 4'b1100, 1'b1, 1'b0);
    step(1, 1, 0, 0); step(0, 1, 0, 0); step(1, 1, 0, 0);
    step(0, 1, 0, 0); step(1, 1, 0, 0);
    chk("tp2_cnt0", 32'(cnt0), 32'(1 * CE));
    chk("tp2_y0_nomatch", 32'(y0), 32'd0);

    // 4-bit pattern 1100 on the wide instance.
    do_load(3'b101, 4'b1100, 1'b1, 1'b1);
    for (int r = 0; r < 2; r++) begin
      step(1, 1, 0, 1); step(1, 1, 0, 1); step(0, 1, 0, 1); step(0, 1, 0, 1);
      chk("tp3_y1", 32'(y1), 32'd1);
    end
    chk("tp3_cnt1", 32'(cnt1), 32'(2 * CE));
    chk("tp3_pat1", 32'(pq1), 32'hC);

    // en=0 gap holds history.
    do_load(3'b101, 4'b1100, 1'b0, 1'b1);
    step(1, 1, 0, 1);
    step(0, 0, 0, 1); step(1, 0, 0, 1); step(0, 0, 0, 1);
    step(0, 1, 0, 1); step(1, 1, 0, 1);
    chk("tp4_y0", 32'(y0), 32'd1);
    chk("tp4_cnt0", 32'(cnt0), 32'(1 * CE));

    // Reset mid-sequence discards partial progress and the loaded pattern.
    step(1, 1, 0, 1); step(0, 1, 0, 1);
    do_reset();
    chk("tp5_pat1", 32'(pq1), 32'h6);
    step(1, 1, 0, 1);
    chk("tp5_y0_quiet", 32'(y0), 32'd0);
    step(0, 1, 0, 1); step(1, 1, 0, 1);
    chk("tp5_y0_pulse", 32'(y0), 32'd1);

    // Counter saturation on the 2-bit counter with pattern 1010.
    do_load(3'b101, 4'b1010, 1'b0, 1'b1);
    step(1, 1, 0, 1); step(0, 1, 0, 1);
    for (int m = 1; m <= 5; m++) begin
      step(1, 1, 0, 1); step(0, 1, 0, 1);
      chk("tp6_cnt1", 32'(cnt1), 32'(CE * ((m < 3) ? m : 3)));
    end
    do_load(3'b101, 4'b1010, 1'b0, 1'b1);
    chk("tp6_cnt1_clear", 32'(cnt1), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        pin0 = 3'($urandom_range(0, 7));
        pin1 = 4'($urandom_range(0, 15));
        step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised Moore-style serial pattern detector; next generation of the team's fixed 3-bit sequence detector.
- Adds programmable pattern of width PAT_W, a bit-valid qualifier, overlapping/non-overlapping match mode and a saturating match counter.
- Sits on a serial bit stream, e.g. from a switch debouncer or UART-style shifter, and drives a match pulse to downstream LED/counter logic.
- With defaults (PAT_W=3, PAT_RST=3'b101), en=1 and overlap=1, it is cycle-equivalent to the existing 101 overlapping detector.

Parameters:
- PAT_W, 3, pattern length in bits; legal range 2..16.
- PAT_RST, 3'b101, pattern loaded at reset; PAT_W bits wide.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- X  input  1  serial data bit; sampled only when en=1.
- en  input  1  bit-valid qualifier.
- load  input  1  one-cycle strobe; captures pattern_in and clears history and counter.
- pattern_in  input  PAT_W  new pattern; pattern_in[PAT_W-1] is the first bit expected on the line.
- overlap  input  1  1 = overlapping matches, 0 = non-overlapping; sampled on every edge.
- Y  output  1  registered match pulse.
- match_cnt  output  CNT_W  number of matches since the last reset or load; saturating.
- pattern_q  output  PAT_W  currently active pattern.

Behaviour:
- Reset (async, rst_n=0):
  - history=0, fill=0, state=FILL, pattern_q=PAT_RST.
  - Y=0, match_cnt=0.
- History register:
  - PAT_W bits, shifts left, new X enters at bit 0, so the oldest bit sits in bit PAT_W-1.
  - fill counter is clog2(PAT_W+1) bits and saturates at PAT_W.
- FSM, two states:
  - FILL: fill<PAT_W. Each en=1 edge shifts X in and increments fill. When fill reaches PAT_W on that edge, go to HUNT and evaluate a match on the same edge.
  - HUNT: history holds PAT_W valid bits. Each en=1 edge shifts X in and evaluates a match.
- Match condition: the post-shift history equals pattern_q, and fill would be PAT_W after the shift.
  - On a match, Y<=1 on that edge, so Y is high for the following cycle. Latency is 1 clock from the edge that samples the final bit.
  - On any edge without a match (including en=0 edges), Y<=0. Y is therefore a one-cycle pulse per match.
  - Back-to-back matches, e.g. pattern 111 in overlap mode with a run of ones, hold Y high on consecutive cycles.
- Overlap mode:
  - overlap=1: history is kept after a match and the state stays HUNT.
  - overlap=0: on a match, fill<=0 and state<=FILL. The next match needs PAT_W fresh bits.
- en=0: history, fill and state hold; X is ignored.
- load=1: highest priority (above en).
  - pattern_q<=pattern_in, fill<=0, state<=FILL, Y<=0, match_cnt<=0.
  - The bit on X in the load cycle is discarded.
- match_cnt:
  - Increments by 1 on each edge that sets Y.
  - Holds at 2^CNT_W-1; no wrap.
- Reset mid-sequence: all partial progress is lost, and the pattern reverts to PAT_RST (not the last loaded pattern).

Optional Feature:
- Macro: SEQDET_CNT_EN.
- Defined: match_cnt behaves as described above.
- Undefined: no counter flops are built and match_cnt is tied to 0. Y and all other behaviour are unchanged.

Test Plan:
- Defaults, en=1, overlap=1, X=1,0,1,0,1 -> Y pulses in the cycles after bits 3 and 5; match_cnt=2.
- Same stream with overlap=0 -> single Y pulse after bit 3; match_cnt=1. Bits 4 and 5 give fill=2, so no match.
- PAT_W=4 instance, load with pattern_in=4'b1100, then X=1,1,0,0,1,1,0,0 -> Y after bits 4 and 8; pattern_q=4'b1100. The X value in the load cycle has no effect.
- Defaults; X=1 (en=1); then 3 cycles en=0 with X toggling; then X=0,1 (en=1) -> exactly one Y pulse, after the final 1.
- Defaults; X=1,0, then rst_n=0 for 1 cycle, then X=1 -> Y stays 0. Then X=0,1 -> Y pulses.
- CNT_W=2, overlap=1, stream of 1,0 repeated giving 5 matches -> match_cnt reads 1,2,3,3,3. A load pulse then clears it to 0.
